// File: rtl/mfp_ahb_rojobot_if_pkg.sv
// Shared constants for the Rojobot AHB-Lite interface: register offsets,
// CFG/STATUS/CMD bit positions, ack FSM state encodings and a STATUS packer.
package mfp_ahb_rojobot_if_pkg;

   // Word offsets (HADDR[3:2]) of the four registers
   localparam logic [1:0] OFF_BOTINFO = 2'd0;
   localparam logic [1:0] OFF_BOTCTRL = 2'd1;
   localparam logic [1:0] OFF_CFG     = 2'd2;
   localparam logic [1:0] OFF_STATUS  = 2'd3;

   // CFG bit positions
   localparam int CFG_AUTO_ACK = 0;
   localparam int CFG_IRQ_EN   = 1;

   // CMD (write side of offset 0xC) bit positions
   localparam int CMD_ACK = 0;
   localparam int CMD_CLR = 1;

   // Ack FSM state encodings
   typedef enum logic [1:0] {
      ACK_IDLE = 2'd0,
      ACK_HOLD = 2'd1,
      ACK_REL  = 2'd2
   } ack_state_e;

   // Packs the STATUS read word
   function automatic logic [31:0] status_word(input logic timeout,
                                               input logic overrun,
                                               input logic valid,
                                               input logic sync);
      return {28'h0000000, timeout, overrun, valid, sync};
   endfunction

endpackage

// File: rtl/mfp_ahb_rojobot_if_ack_fsm.sv
// Ack handshake FSM: raises H_INT_ACK on a request, holds it until the update
// flip-flop clears (or the hold budget runs out), then releases for one cycle.
module rojobot_ack_fsm
   import mfp_ahb_rojobot_if_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic req,
   input  logic sync,
   output logic H_INT_ACK,
   output logic timeout_pulse
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ack_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ack_r;
   logic             pulse_r;

   // State, hold counter and registered ack/timeout outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r <= ACK_IDLE;
         cnt_r   <= '0;
         ack_r   <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         case (state_r)
            ACK_IDLE: begin
               pulse_r <= 1'b0;
               if (req) begin
                  state_r <= ACK_HOLD;
                  cnt_r   <= '0;
                  ack_r   <= 1'b1;
               end else begin
                  ack_r   <= 1'b0;
               end
            end
            ACK_HOLD: begin
               if (!sync) begin
                  state_r <= ACK_REL;
                  ack_r   <= 1'b0;
                  pulse_r <= 1'b0;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= ACK_REL;
                  ack_r   <= 1'b0;
                  pulse_r <= 1'b1;
               end else begin
                  ack_r   <= 1'b1;
                  pulse_r <= 1'b0;
                  // saturate rather than wrap
                  if (cnt_r != CNT_MAX) begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end else begin
                     cnt_r <= cnt_r;
                  end
               end
            end
            ACK_REL: begin
               state_r <= ACK_IDLE;
               ack_r   <= 1'b0;
               pulse_r <= 1'b0;
            end
            default: begin
               state_r <= ACK_IDLE;
               cnt_r   <= '0;
               ack_r   <= 1'b0;
               pulse_r <= 1'b0;
            end
         endcase
      end
   end

   assign H_INT_ACK     = ack_r;
   assign timeout_pulse = pulse_r;

endmodule

// File: rtl/mfp_ahb_rojobot_if.sv
// AHB-Lite slave for the Rojobot: snapshots H_BOT_INFO on each update,
// exposes the motor control register, and drives the ack handshake and IRQ.
module mfp_ahb_rojobot_if
   import mfp_ahb_rojobot_if_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic              HREADY,
   input  logic [31:0]       HWDATA,
   output logic [31:0]       HRDATA,
   input  logic [31:0]       H_BOT_INFO,
   input  logic              H_BOT_UPDATE_SYNC,
   output logic [7:0]        H_BOT_CTRL,
   output logic              H_INT_ACK,
   output logic              IRQ
);

   logic        dp_valid_r, dp_write_r;
   logic [1:0]  dp_addr_r;
   logic [31:0] snapshot_r;
   logic [7:0]  ctrl_r;
   logic        auto_ack_r, irq_en_r;
   logic        valid_r, overrun_r, timeout_r;
   logic        sync_d_r, irq_r;

   logic accept_s, wr_s, rd_s, botinfo_rd_s;
   logic ctrl_wr_s, cfg_wr_s, cmd_wr_s, cmd_ack_s, cmd_clr_s;
   logic rise_s, overrun_set_s, ack_req_s, timeout_pulse_s;
   logic valid_nx_s, irq_en_nx_s;
   logic unused_ok_s;

   assign accept_s      = HSEL & HTRANS[1] & HREADY;
   assign wr_s          = dp_valid_r & dp_write_r;
   assign rd_s          = dp_valid_r & ~dp_write_r;
   assign botinfo_rd_s  = rd_s & (dp_addr_r == OFF_BOTINFO);
   assign ctrl_wr_s     = wr_s & (dp_addr_r == OFF_BOTCTRL);
   assign cfg_wr_s      = wr_s & (dp_addr_r == OFF_CFG);
   assign cmd_wr_s      = wr_s & (dp_addr_r == OFF_STATUS);
   assign cmd_ack_s     = cmd_wr_s & HWDATA[CMD_ACK];
   assign cmd_clr_s     = cmd_wr_s & HWDATA[CMD_CLR];
   assign rise_s        = H_BOT_UPDATE_SYNC & ~sync_d_r;
   // a rise landing on a completing BOTINFO read replaces the data, not an overrun
   assign overrun_set_s = rise_s & valid_r & ~botinfo_rd_s;
   assign ack_req_s     = cmd_ack_s | (auto_ack_r & rise_s);
   assign unused_ok_s   = ^{HADDR, HTRANS[0], HWDATA};

   // Next-state of valid and irq_en, shared by the IRQ register
   always_comb begin
      valid_nx_s  = valid_r;
      irq_en_nx_s = irq_en_r;
      if (rise_s) begin
         valid_nx_s = 1'b1;
      end else if (botinfo_rd_s) begin
         valid_nx_s = 1'b0;
      end else begin
         valid_nx_s = valid_r;
      end
      if (cfg_wr_s) begin
         irq_en_nx_s = HWDATA[CFG_IRQ_EN];
      end else begin
         irq_en_nx_s = irq_en_r;
      end
   end

   // Address-phase capture into the data-phase pipeline register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid_r <= 1'b0;
         dp_write_r <= 1'b0;
         dp_addr_r  <= 2'd0;
      end else if (accept_s) begin
         dp_valid_r <= 1'b1;
         dp_write_r <= HWRITE;
         dp_addr_r  <= HADDR[3:2];
      end else begin
         dp_valid_r <= 1'b0;
      end
   end

   // Software registers, update capture, sticky flags and IRQ
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         snapshot_r <= 32'h0;
         ctrl_r     <= 8'h00;
         auto_ack_r <= 1'b0;
         irq_en_r   <= 1'b0;
         valid_r    <= 1'b0;
         overrun_r  <= 1'b0;
         timeout_r  <= 1'b0;
         sync_d_r   <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         sync_d_r <= H_BOT_UPDATE_SYNC;
         valid_r  <= valid_nx_s;
         irq_en_r <= irq_en_nx_s;
         irq_r    <= valid_nx_s & irq_en_nx_s;
         if (rise_s) begin
            snapshot_r <= H_BOT_INFO;
         end
         if (ctrl_wr_s) begin
            ctrl_r <= HWDATA[7:0];
         end
         if (cfg_wr_s) begin
            auto_ack_r <= HWDATA[CFG_AUTO_ACK];
         end
         if (overrun_set_s) begin
            overrun_r <= 1'b1;
         end else if (cmd_clr_s) begin
            overrun_r <= 1'b0;
         end
         if (timeout_pulse_s) begin
            timeout_r <= 1'b1;
         end else if (cmd_clr_s) begin
            timeout_r <= 1'b0;
         end
      end
   end

   // Data-phase read mux; zero when no read is in its data phase
   always_comb begin
      HRDATA = 32'h0;
      if (rd_s) begin
         case (dp_addr_r)
            OFF_BOTINFO: HRDATA = snapshot_r;
            OFF_BOTCTRL: HRDATA = {24'h000000, ctrl_r};
            OFF_CFG:     HRDATA = {30'h0, irq_en_r, auto_ack_r};
            OFF_STATUS:  HRDATA = status_word(timeout_r, overrun_r, valid_r, H_BOT_UPDATE_SYNC);
            default:     HRDATA = 32'h0;
         endcase
      end else begin
         HRDATA = 32'h0;
      end
   end

   rojobot_ack_fsm #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_ack_fsm (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .req           (ack_req_s),
      .sync          (H_BOT_UPDATE_SYNC),
      .H_INT_ACK     (H_INT_ACK),
      .timeout_pulse (timeout_pulse_s)
   );

   assign H_BOT_CTRL = ctrl_r;
   assign IRQ        = irq_r;

endmodule

// File: tb/tb_mfp_ahb_rojobot_if.sv
// Directed bench for mfp_ahb_rojobot_if: a register-access vector table plus
// hand-written sequences for reset, capture, ack handshake, timeout and overrun.
module tb_mfp_ahb_rojobot_if;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [3:0]  haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic        hready;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic [31:0] bot_info;
   logic        bot_sync;
   logic [7:0]  bot_ctrl;
   logic        int_ack;
   logic        irq;

   int total = 0;
   int bad   = 0;

   mfp_ahb_rojobot_if #(.ADDR_W(4), .ACK_TIMEOUT(16)) dut (
      .HCLK              (hclk),
      .HRESETn           (hresetn),
      .HSEL              (hsel),
      .HADDR             (haddr),
      .HTRANS            (htrans),
      .HWRITE            (hwrite),
      .HREADY            (hready),
      .HWDATA            (hwdata),
      .HRDATA            (hrdata),
      .H_BOT_INFO        (bot_info),
      .H_BOT_UPDATE_SYNC (bot_sync),
      .H_BOT_CTRL        (bot_ctrl),
      .H_INT_ACK         (int_ack),
      .IRQ               (irq)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [7:0]  exp_ctrl;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
      @(negedge hclk);
   endtask

   task automatic ahb_read(input logic [3:0] a, output logic [31:0] d, output logic irq_dp);
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00;
      d = hrdata;
      irq_dp = irq;
      @(negedge hclk);
   endtask

   initial begin
      logic [31:0] rd;
      logic        irq_dp;
      logic [3:0]  ack_seq;
      int          hi;
      int          guard;

      hresetn = 1'b0; hsel = 1'b0; haddr = 4'h0; htrans = 2'b00; hwrite = 1'b0;
      hready = 1'b1; hwdata = 32'h0; bot_info = 32'h0; bot_sync = 1'b0;
      repeat (2) @(negedge hclk);
      check("rst_hrdata", hrdata, 32'h0);
      check("rst_ctrl", {24'h0, bot_ctrl}, 32'h0);
      check("rst_ack", {31'h0, int_ack}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      hresetn = 1'b1;

      // register access table
      vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h0,        8'h00};
      vecs[1]  = '{1'b1, 4'h4, 32'hFFFF00A5, 32'h0,        8'hA5};
      vecs[2]  = '{1'b0, 4'h4, 32'h0,        32'h000000A5, 8'hA5};
      vecs[3]  = '{1'b1, 4'h8, 32'hFFFFFFFE, 32'h0,        8'hA5};
      vecs[4]  = '{1'b0, 4'h8, 32'h0,        32'h00000002, 8'hA5};
      vecs[5]  = '{1'b1, 4'h4, 32'h0000003C, 32'h0,        8'h3C};
      vecs[6]  = '{1'b0, 4'h4, 32'h0,        32'h0000003C, 8'h3C};
      vecs[7]  = '{1'b0, 4'hC, 32'h0,        32'h0,        8'h3C};
      vecs[8]  = '{1'b0, 4'h0, 32'h0,        32'h0,        8'h3C};
      vecs[9]  = '{1'b1, 4'h8, 32'h0,        32'h0,        8'h3C};
      vecs[10] = '{1'b0, 4'h8, 32'h0,        32'h0,        8'h3C};
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].wr) begin
            ahb_write(vecs[i].addr, vecs[i].wdata);
         end else begin
            ahb_read(vecs[i].addr, rd, irq_dp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         end
         check($sformatf("vec%0d_ctrl", i), {24'h0, bot_ctrl}, {24'h0, vecs[i].exp_ctrl});
      end

      // back-to-back write BOTCTRL then read BOTCTRL
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 4'h4;
      @(negedge hclk);
      hwdata = 32'h0000005A; hwrite = 1'b0; haddr = 4'h4;
      check("b2b_ctrl_dataphase", {24'h0, bot_ctrl}, 32'h3C);
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00;
      check("b2b_rdata", hrdata, 32'h0000005A);
      check("b2b_ctrl_after", {24'h0, bot_ctrl}, 32'h5A);
      @(negedge hclk);
      check("idle_hrdata", hrdata, 32'h0);

      // reset asserted mid-ack
      ahb_write(4'h4, 32'h00000077);
      bot_sync = 1'b1;
      ahb_write(4'hC, 32'h00000001);
      check("midrst_ack_before", {31'h0, int_ack}, 32'h1);
      hresetn = 1'b0;
      #1;
      check("midrst_ack_async", {31'h0, int_ack}, 32'h0);
      check("midrst_ctrl", {24'h0, bot_ctrl}, 32'h0);
      bot_sync = 1'b0;
      @(negedge hclk);
      hresetn = 1'b1;
      check("midrst_irq", {31'h0, irq}, 32'h0);
      ahb_read(4'hC, rd, irq_dp);
      check("midrst_status", rd, 32'h0);
      ahb_read(4'h0, rd, irq_dp);
      check("midrst_botinfo", rd, 32'h0);

      // capture and read with irq enabled
      ahb_write(4'h8, 32'h00000002);
      bot_info = 32'h12345678;
      bot_sync = 1'b1;
      @(negedge hclk);
      check("cap_irq", {31'h0, irq}, 32'h1);
      ahb_read(4'hC, rd, irq_dp);
      check("cap_status", rd, 32'h3);
      bot_sync = 1'b0;
      ahb_read(4'h0, rd, irq_dp);
      check("cap_botinfo", rd, 32'h12345678);
      check("cap_irq_dataphase", {31'h0, irq_dp}, 32'h1);
      check("cap_irq_after", {31'h0, irq}, 32'h0);
      ahb_read(4'hC, rd, irq_dp);
      check("cap_status_after", rd, 32'h0);

      // manual ack, update flip-flop clears as soon as ack rises
      bot_sync = 1'b1;
      @(negedge hclk);
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 4'hC;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1;
      check("mack_ack_dataphase", {31'h0, int_ack}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge hclk);
         ack_seq[i] = int_ack;
         if (int_ack) bot_sync = 1'b0;
      end
      check("mack_ack_seq", {28'h0, ack_seq}, 32'h1);
      check("mack_sync", {31'h0, bot_sync}, 32'h0);
      ahb_read(4'hC, rd, irq_dp);
      check("mack_status", rd, 32'h2);
      ahb_read(4'h0, rd, irq_dp);
      check("mack_botinfo", rd, 32'h12345678);

      // auto ack with sync stuck high -> timeout
      ahb_write(4'h8, 32'h00000001);
      bot_sync = 1'b1;
      guard = 0;
      while (!int_ack && guard < 5) begin
         @(negedge hclk);
         guard++;
      end
      check("tmo_ack_seen", {31'h0, int_ack}, 32'h1);
      hi = 0;
      guard = 0;
      while (int_ack && guard < 40) begin
         hi++;
         guard++;
         @(negedge hclk);
      end
      check("tmo_ack_len", hi, 32'd16);
      ahb_read(4'hC, rd, irq_dp);
      check("tmo_status", rd, 32'hB);
      ahb_write(4'hC, 32'h00000002);
      ahb_read(4'hC, rd, irq_dp);
      check("tmo_status_clr", rd, 32'h3);
      check("tmo_no_reack", {31'h0, int_ack}, 32'h0);
      ahb_write(4'h8, 32'h0);
      bot_sync = 1'b0;
      ahb_read(4'h0, rd, irq_dp);

      // overrun: two rises with no read
      bot_info = 32'hAAAA0001; bot_sync = 1'b1;
      @(negedge hclk); bot_sync = 1'b0;
      @(negedge hclk);
      bot_info = 32'hBBBB0002; bot_sync = 1'b1;
      @(negedge hclk); bot_sync = 1'b0;
      @(negedge hclk);
      ahb_read(4'hC, rd, irq_dp);
      check("ovr_status", rd, 32'h6);
      ahb_read(4'h0, rd, irq_dp);
      check("ovr_botinfo", rd, 32'hBBBB0002);
      ahb_write(4'hC, 32'h00000002);
      ahb_read(4'hC, rd, irq_dp);
      check("ovr_status_clr", rd, 32'h0);

      // rise coinciding with a BOTINFO read data phase
      bot_info = 32'hCCCC0003; bot_sync = 1'b1;
      @(negedge hclk); bot_sync = 1'b0;
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 4'h0;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00;
      check("coin_rdata", hrdata, 32'hCCCC0003);
      bot_info = 32'hDDDD0004; bot_sync = 1'b1;
      @(negedge hclk);
      bot_sync = 1'b0;
      ahb_read(4'hC, rd, irq_dp);
      check("coin_status", rd, 32'h2);
      ahb_read(4'h0, rd, irq_dp);
      check("coin_botinfo", rd, 32'hDDDD0004);
      ahb_read(4'hC, rd, irq_dp);
      check("coin_status_after", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
